// File: rtl/dm_arb_pkg.sv
// ============================================================================
//  Module   : dm_arb_pkg
//  Purpose  : Shared types and constants for the data-memory port arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dm_arb_pkg;

   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage : dm_arb_pkg

`default_nettype wire

// File: rtl/dm_port_arbiter_if.sv
// ============================================================================
//  Module   : dm_port_arbiter_if
//  Purpose  : Core, DMA and memory-side signals of the data-memory port arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface dm_port_arbiter_if #(
   parameter int DMA_SIZE = 17,
   parameter int DMD_SIZE = 16
);
   logic                core_dm_cslt;
   logic                core_dm_wrb;
   logic [DMA_SIZE-1:0] core_dm_add;
   logic [DMD_SIZE-1:0] core_dm_wdt;
   logic                core_stall;

   logic                dma_req;
   logic                dma_wrb;
   logic [DMA_SIZE-1:0] dma_add;
   logic [DMD_SIZE-1:0] dma_wdt;
   logic                dma_gnt;
   logic                dma_rvalid;
   logic [DMD_SIZE-1:0] dma_rdt;

   logic                ps_dm_cslt;
   logic                ps_dm_wrb;
   logic [DMA_SIZE-1:0] dg_dm_add;
   logic [DMD_SIZE-1:0] bc_dt;
   logic [DMD_SIZE-1:0] dm_bc_dt;

   // Arbiter view
   modport slave (
      input  core_dm_cslt, core_dm_wrb, core_dm_add, core_dm_wdt,
      output core_stall,
      input  dma_req, dma_wrb, dma_add, dma_wdt,
      output dma_gnt, dma_rvalid, dma_rdt,
      output ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
      input  dm_bc_dt
   );

   // Requesters and memory view
   modport master (
      output core_dm_cslt, core_dm_wrb, core_dm_add, core_dm_wdt,
      input  core_stall,
      output dma_req, dma_wrb, dma_add, dma_wdt,
      input  dma_gnt, dma_rvalid, dma_rdt,
      input  ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
      output dm_bc_dt
   );

endinterface : dm_port_arbiter_if

`default_nettype wire

// File: rtl/dm_starve_counter.sv
// ============================================================================
//  Module   : dm_starve_counter
//  Purpose  : Saturating count of consecutive denied DMA cycles with limit flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dm_starve_counter
   import dm_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_lim
);

   localparam logic [STARVE_W-1:0] c_LIMIT = STARVE_W'(LIMIT);

   logic [STARVE_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != c_LIMIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_at_lim = (r_cnt == c_LIMIT);

endmodule : dm_starve_counter

`default_nettype wire

// File: rtl/dm_port_arbiter.sv
// ============================================================================
//  Module   : dm_port_arbiter
//  Purpose  : Shares the single data-memory port between core and DMA, with
//             write-data and read-return pipelining and DMA starvation guard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DMA_SIZE   = 17,
   parameter int DMD_SIZE   = 16,
   parameter int STARVE_LIM = 4
) (
   input  logic             clk,
   input  logic             reset,
   dm_port_arbiter_if.slave bus
);

   owner_e              w_owner;
   logic                w_force;
   logic                w_dma_gnt;
   logic                w_cslt;
   logic                w_wrb;
   logic [DMA_SIZE-1:0] w_add;
   logic [DMD_SIZE-1:0] w_bc_dt;
   logic [DMD_SIZE-1:0] w_dma_rdt;

   owner_e              r_wr_src;
   logic [DMA_SIZE-1:0] r_add;
   logic [DMD_SIZE-1:0] r_wdata;
   logic [DMD_SIZE-1:0] r_bc;
   logic [DMD_SIZE-1:0] r_rdt;
   logic                r_rd_pend;

   dm_starve_counter #(
      .LIMIT (STARVE_LIM)
   ) u_starve (
      .clk      (clk),
      .reset    (reset),
      .i_inc    (bus.dma_req & ~w_dma_gnt),
      .i_clr    (w_dma_gnt | ~bus.dma_req),
      .o_at_lim (w_force)
   );

   // Reset gates the owner so every memory-side output is zero while held.
   always_comb begin : p_arb
      w_owner = OWN_NONE;
      if (reset) begin
         if (w_force && bus.dma_req) begin
            w_owner = OWN_DMA;
         end else if (bus.core_dm_cslt) begin
            w_owner = OWN_CORE;
         end else if (bus.dma_req) begin
            w_owner = OWN_DMA;
         end
      end
   end

   always_comb begin : p_mem_drive
      w_wrb = 1'b0;
      w_add = r_add;
      case (w_owner)
         OWN_CORE: begin
            w_wrb = bus.core_dm_wrb;
            w_add = bus.core_dm_add;
         end
         OWN_DMA: begin
            w_wrb = bus.dma_wrb;
            w_add = bus.dma_add;
         end
         default: ;
      endcase

      // Core write data only arrives in the cycle after its grant.
      w_bc_dt = r_bc;
      case (r_wr_src)
         OWN_CORE: w_bc_dt = bus.core_dm_wdt;
         OWN_DMA:  w_bc_dt = r_wdata;
         default:  ;
      endcase
   end

   assign w_cslt    = (w_owner != OWN_NONE);
   assign w_dma_gnt = (w_owner == OWN_DMA);
   assign w_dma_rdt = r_rd_pend ? bus.dm_bc_dt : r_rdt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_src  <= OWN_NONE;
         r_add     <= '0;
         r_wdata   <= '0;
         r_bc      <= '0;
         r_rdt     <= '0;
         r_rd_pend <= 1'b0;
      end else begin
         r_wr_src  <= (w_cslt && w_wrb) ? w_owner : OWN_NONE;
         r_add     <= w_add;
         r_bc      <= w_bc_dt;
         r_rdt     <= w_dma_rdt;
         r_rd_pend <= w_dma_gnt & ~bus.dma_wrb;
         if (w_dma_gnt && bus.dma_wrb) begin
            r_wdata <= bus.dma_wdt;
         end
      end
   end

   assign bus.ps_dm_cslt = w_cslt;
   assign bus.ps_dm_wrb  = w_wrb;
   assign bus.dg_dm_add  = w_add;
   assign bus.bc_dt      = w_bc_dt;
   assign bus.core_stall = reset & bus.core_dm_cslt & (w_owner != OWN_CORE);
   assign bus.dma_gnt    = w_dma_gnt;
   assign bus.dma_rvalid = r_rd_pend;
   assign bus.dma_rdt    = w_dma_rdt;

   // A DMA request must stay up until it is granted.
   a_dma_hold : assert property (@(posedge clk) disable iff (!reset)
                                 (bus.dma_req && !w_dma_gnt) |=> bus.dma_req);

endmodule : dm_port_arbiter

`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
// ============================================================================
//  Module   : tb_dm_port_arbiter
//  Purpose  : Self-checking bench for dm_port_arbiter with a memory responder
//             and a spec-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_port_arbiter;
   localparam int AW  = 17;
   localparam int DW  = 16;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_port_arbiter_if #(.DMA_SIZE(AW), .DMD_SIZE(DW)) bus ();

   dm_port_arbiter #(.DMA_SIZE(AW), .DMD_SIZE(DW), .STARVE_LIM(LIM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Memory responder: write commits with bc_dt in grant+1, read data next cycle
   logic [DW-1:0] tm_mem [64];
   logic          tm_wr_pend = 1'b0;
   logic [5:0]    tm_wr_addr = '0;
   logic          tm_rd_go   = 1'b0;
   logic [DW-1:0] tm_rd_next = '0;

   always @(negedge clk) begin
      if (tm_wr_pend) tm_mem[tm_wr_addr] = bus.bc_dt;
      tm_rd_go = bus.ps_dm_cslt && !bus.ps_dm_wrb;
      if (tm_rd_go) tm_rd_next = tm_mem[bus.dg_dm_add[5:0]];
      tm_wr_pend = bus.ps_dm_cslt && bus.ps_dm_wrb;
      tm_wr_addr = bus.dg_dm_add[5:0];
   end

   always @(posedge clk) begin
      #1;
      if (tm_rd_go) bus.dm_bc_dt = tm_rd_next;
   end

   // Reference model state
   int            m_denied;
   logic [AW-1:0] m_last_add;
   logic [DW-1:0] m_last_bc, m_last_rdt, m_wr_dma_data, m_rd_val;
   int            m_wr_kind;          // 0 none, 1 core, 2 dma
   logic [5:0]    m_wr_addr;
   logic          m_rd_due;
   logic [DW-1:0] shadow [64];

   logic          e_cslt, e_wrb, e_stall, e_gnt, e_rvalid;
   logic [AW-1:0] e_add;
   logic [DW-1:0] e_bc, e_rdt;
   logic          c_reset, c_dma_req, c_dma_wrb;
   logic [AW-1:0] c_dma_add;
   logic [DW-1:0] c_dma_wdt;

   task automatic model_reset();
      m_denied = 0; m_last_add = '0; m_last_bc = '0; m_last_rdt = '0;
      m_wr_dma_data = '0; m_rd_val = '0; m_wr_kind = 0; m_wr_addr = '0; m_rd_due = 1'b0;
   endtask

   task automatic model_eval();
      bit dma_wins, core_wins;
      c_reset = reset; c_dma_req = bus.dma_req; c_dma_wrb = bus.dma_wrb;
      c_dma_add = bus.dma_add; c_dma_wdt = bus.dma_wdt;
      if (!reset) begin
         model_reset();
         e_cslt = 0; e_wrb = 0; e_stall = 0; e_gnt = 0; e_rvalid = 0;
         e_add = '0; e_bc = '0; e_rdt = '0;
      end else begin
         dma_wins  = bus.dma_req && (m_denied == LIM || !bus.core_dm_cslt);
         core_wins = bus.core_dm_cslt && !dma_wins;
         e_cslt  = core_wins || dma_wins;
         e_wrb   = core_wins ? bus.core_dm_wrb : (dma_wins ? bus.dma_wrb : 1'b0);
         e_add   = core_wins ? bus.core_dm_add : (dma_wins ? bus.dma_add : m_last_add);
         e_stall = bus.core_dm_cslt && !core_wins;
         e_gnt   = dma_wins;
         e_bc    = (m_wr_kind == 1) ? bus.core_dm_wdt : (m_wr_kind == 2) ? m_wr_dma_data : m_last_bc;
         e_rvalid = m_rd_due;
         e_rdt   = m_rd_due ? m_rd_val : m_last_rdt;
      end
   endtask

   task automatic model_advance();
      if (c_reset) begin
         if (m_wr_kind != 0) shadow[m_wr_addr] = e_bc;
         m_rd_due = e_gnt && !c_dma_wrb;
         if (m_rd_due) m_rd_val = shadow[c_dma_add[5:0]];
         if (e_cslt && e_wrb) begin
            m_wr_kind = e_gnt ? 2 : 1;
            m_wr_addr = e_add[5:0];
            m_wr_dma_data = c_dma_wdt;
         end else begin
            m_wr_kind = 0;
         end
         m_last_add = e_add; m_last_bc = e_bc; m_last_rdt = e_rdt;
         m_denied = (c_dma_req && !e_gnt) ? ((m_denied < LIM) ? m_denied + 1 : LIM) : 0;
      end
   endtask

   task automatic at_sample();
      @(negedge clk);
      model_eval();
   endtask

   task automatic at_end();
      @(posedge clk);
      model_advance();
      #2;
   endtask

   task automatic drive_core(input logic cs, input logic wrb, input logic [AW-1:0] add, input logic [DW-1:0] wdt);
      bus.core_dm_cslt = cs; bus.core_dm_wrb = wrb; bus.core_dm_add = add; bus.core_dm_wdt = wdt;
   endtask

   task automatic drive_dma(input logic req, input logic wrb, input logic [AW-1:0] add, input logic [DW-1:0] wdt);
      bus.dma_req = req; bus.dma_wrb = wrb; bus.dma_add = add; bus.dma_wdt = wdt;
   endtask

   task automatic test_reset();
      drive_core(1'b1, 1'b1, 17'h1ABCD, 16'h5A5A);
      drive_dma(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         at_sample();
         n_checks++; if (bus.ps_dm_cslt !== 1'b0) begin n_fail++; $display("FAIL rst_cslt: got %b want 0", bus.ps_dm_cslt); end
         n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus.core_stall); end
         n_checks++; if (bus.dg_dm_add !== '0) begin n_fail++; $display("FAIL rst_add: got %h want 0", bus.dg_dm_add); end
         n_checks++; if (bus.bc_dt !== '0) begin n_fail++; $display("FAIL rst_bc: got %h want 0", bus.bc_dt); end
         n_checks++; if ({bus.ps_dm_wrb, bus.dma_gnt, bus.dma_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl: got %b want 000", {bus.ps_dm_wrb, bus.dma_gnt, bus.dma_rvalid}); end
         n_checks++; if (bus.dma_rdt !== '0) begin n_fail++; $display("FAIL rst_rdt: got %h want 0", bus.dma_rdt); end
         at_end();
      end
      drive_core(1'b0, 1'b0, '0, '0);
      reset = 1'b1;
   endtask

   task automatic test_core_reads();
      drive_core(1'b1, 1'b0, 17'h0000A, '0);
      at_sample();
      n_checks++; if ({bus.ps_dm_cslt, bus.core_stall, bus.ps_dm_wrb} !== 3'b100) begin n_fail++; $display("FAIL crd0_ctl: got %b want 100", {bus.ps_dm_cslt, bus.core_stall, bus.ps_dm_wrb}); end
      n_checks++; if (bus.dg_dm_add !== 17'h0000A) begin n_fail++; $display("FAIL crd0_add: got %h want 0000a", bus.dg_dm_add); end
      at_end();
      drive_core(1'b1, 1'b0, 17'h0000F, '0);
      at_sample();
      n_checks++; if ({bus.ps_dm_cslt, bus.core_stall, bus.ps_dm_wrb} !== 3'b100) begin n_fail++; $display("FAIL crd1_ctl: got %b want 100", {bus.ps_dm_cslt, bus.core_stall, bus.ps_dm_wrb}); end
      n_checks++; if (bus.dg_dm_add !== 17'h0000F) begin n_fail++; $display("FAIL crd1_add: got %h want 0000f", bus.dg_dm_add); end
      at_end();
      drive_core(1'b0, 1'b0, '0, '0);
      at_sample();
      n_checks++; if (bus.ps_dm_cslt !== 1'b0) begin n_fail++; $display("FAIL crd_idle_cslt: got %b want 0", bus.ps_dm_cslt); end
      n_checks++; if (bus.dg_dm_add !== 17'h0000F) begin n_fail++; $display("FAIL crd_idle_add: got %h want 0000f", bus.dg_dm_add); end
      at_end();
   endtask

   task automatic test_dma_wr_rd();
      drive_dma(1'b1, 1'b1, 17'h00003, 16'hFFEE);
      at_sample();
      n_checks++; if ({bus.dma_gnt, bus.ps_dm_cslt, bus.ps_dm_wrb} !== 3'b111) begin n_fail++; $display("FAIL dwr_ctl: got %b want 111", {bus.dma_gnt, bus.ps_dm_cslt, bus.ps_dm_wrb}); end
      n_checks++; if (bus.dg_dm_add !== 17'h00003) begin n_fail++; $display("FAIL dwr_add: got %h want 00003", bus.dg_dm_add); end
      at_end();
      drive_dma(1'b1, 1'b0, 17'h00003, 16'h0000);
      at_sample();
      n_checks++; if ({bus.dma_gnt, bus.ps_dm_wrb} !== 2'b10) begin n_fail++; $display("FAIL drd_ctl: got %b want 10", {bus.dma_gnt, bus.ps_dm_wrb}); end
      n_checks++; if (bus.bc_dt !== 16'hFFEE) begin n_fail++; $display("FAIL dwr_bc: got %h want ffee", bus.bc_dt); end
      at_end();
      drive_dma(1'b0, 1'b0, '0, '0);
      at_sample();
      n_checks++; if (bus.dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL drd_rvalid: got %b want 1", bus.dma_rvalid); end
      n_checks++; if (bus.dma_rdt !== 16'hFFEE) begin n_fail++; $display("FAIL drd_rdt: got %h want ffee", bus.dma_rdt); end
      at_end();
      at_sample();
      n_checks++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL drd_rvalid_drop: got %b want 0", bus.dma_rvalid); end
      n_checks++; if (bus.dma_rdt !== 16'hFFEE) begin n_fail++; $display("FAIL drd_rdt_hold: got %h want ffee", bus.dma_rdt); end
      at_end();
   endtask

   task automatic test_contention();
      logic exp_dma;
      drive_core(1'b1, 1'b0, 17'h00020, '0);
      drive_dma(1'b1, 1'b0, 17'h00021, '0);
      for (int i = 0; i < 10; i++) begin
         exp_dma = ((i % 5) == 4);
         at_sample();
         n_checks++; if (bus.dma_gnt !== exp_dma) begin n_fail++; $display("FAIL cont_gnt cyc %0d: got %b want %b", i, bus.dma_gnt, exp_dma); end
         n_checks++; if (bus.core_stall !== exp_dma) begin n_fail++; $display("FAIL cont_stall cyc %0d: got %b want %b", i, bus.core_stall, exp_dma); end
         n_checks++; if (dut.u_starve.r_cnt !== 4'(i % 5)) begin n_fail++; $display("FAIL cont_starve cyc %0d: got %0d want %0d", i, dut.u_starve.r_cnt, i % 5); end
         at_end();
      end
      drive_core(1'b0, 1'b0, '0, '0);
      drive_dma(1'b0, 1'b0, '0, '0);
      at_sample();
      n_checks++; if (dut.u_starve.r_cnt !== 4'd0) begin n_fail++; $display("FAIL cont_starve_clr: got %0d want 0", dut.u_starve.r_cnt); end
      at_end();
   endtask

   task automatic test_mixed_writes();
      drive_core(1'b1, 1'b1, 17'h00010, 16'h0000);
      drive_dma(1'b1, 1'b1, 17'h00011, 16'hABCD);
      at_sample();
      n_checks++; if ({bus.core_stall, bus.dma_gnt, bus.ps_dm_wrb} !== 3'b001) begin n_fail++; $display("FAIL mix1_ctl: got %b want 001", {bus.core_stall, bus.dma_gnt, bus.ps_dm_wrb}); end
      n_checks++; if (bus.dg_dm_add !== 17'h00010) begin n_fail++; $display("FAIL mix1_add: got %h want 00010", bus.dg_dm_add); end
      at_end();
      drive_core(1'b0, 1'b0, '0, 16'h1234);
      at_sample();
      n_checks++; if (bus.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL mix2_gnt: got %b want 1", bus.dma_gnt); end
      n_checks++; if (bus.bc_dt !== 16'h1234) begin n_fail++; $display("FAIL mix2_bc: got %h want 1234", bus.bc_dt); end
      at_end();
      drive_core(1'b0, 1'b0, '0, '0);
      drive_dma(1'b1, 1'b0, 17'h00010, '0);
      at_sample();
      n_checks++; if (bus.bc_dt !== 16'hABCD) begin n_fail++; $display("FAIL mix3_bc: got %h want abcd", bus.bc_dt); end
      at_end();
      drive_dma(1'b1, 1'b0, 17'h00011, '0);
      at_sample();
      n_checks++; if ({bus.dma_rvalid, bus.dma_rdt} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL mix4_rd: got %b/%h want 1/1234", bus.dma_rvalid, bus.dma_rdt); end
      at_end();
      drive_dma(1'b0, 1'b0, '0, '0);
      at_sample();
      n_checks++; if ({bus.dma_rvalid, bus.dma_rdt} !== {1'b1, 16'hABCD}) begin n_fail++; $display("FAIL mix5_rd: got %b/%h want 1/abcd", bus.dma_rvalid, bus.dma_rdt); end
      at_end();
   endtask

   task automatic test_reset_mid_read();
      drive_dma(1'b1, 1'b0, 17'h00003, '0);
      at_sample();
      n_checks++; if (bus.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_gnt: got %b want 1", bus.dma_gnt); end
      at_end();
      reset = 1'b0;
      drive_core(1'b1, 1'b0, 17'h00005, '0);
      drive_dma(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 2; i++) begin
         at_sample();
         n_checks++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_rvalid cyc %0d: got %b want 0", i, bus.dma_rvalid); end
         n_checks++; if ({bus.ps_dm_cslt, bus.core_stall, bus.dma_gnt, bus.dg_dm_add, bus.bc_dt, bus.dma_rdt} !== '0) begin
            n_fail++; $display("FAIL rmr_outs cyc %0d: got %b/%b/%b/%h/%h/%h want all 0", i, bus.ps_dm_cslt, bus.core_stall, bus.dma_gnt, bus.dg_dm_add, bus.bc_dt, bus.dma_rdt);
         end
         at_end();
      end
      reset = 1'b1;
      drive_core(1'b0, 1'b0, '0, '0);
      drive_dma(1'b1, 1'b0, 17'h00003, '0);
      at_sample();
      n_checks++; if ({bus.dma_gnt, bus.ps_dm_cslt} !== 2'b11) begin n_fail++; $display("FAIL rmr_resume_gnt: got %b want 11", {bus.dma_gnt, bus.ps_dm_cslt}); end
      at_end();
      drive_dma(1'b0, 1'b0, '0, '0);
      at_sample();
      n_checks++; if ({bus.dma_rvalid, bus.dma_rdt} !== {1'b1, 16'hFFEE}) begin n_fail++; $display("FAIL rmr_resume_rd: got %b/%h want 1/ffee", bus.dma_rvalid, bus.dma_rdt); end
      at_end();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         at_sample();
         n_checks++; if (bus.ps_dm_cslt !== 1'b0) begin n_fail++; $display("FAIL idle_cslt cyc %0d: got %b want 0", i, bus.ps_dm_cslt); end
         n_checks++; if (bus.dg_dm_add !== 17'h00003) begin n_fail++; $display("FAIL idle_add cyc %0d: got %h want 00003", i, bus.dg_dm_add); end
         n_checks++; if (dut.u_starve.r_cnt !== 4'd0) begin n_fail++; $display("FAIL idle_starve cyc %0d: got %0d want 0", i, dut.u_starve.r_cnt); end
         at_end();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.core_dm_wdt = DW'($urandom);
         at_sample();
         n_checks++; if (bus.ps_dm_cslt !== e_cslt) begin n_fail++; $display("FAIL rnd_cslt cyc %0d: got %b want %b", i, bus.ps_dm_cslt, e_cslt); end
         n_checks++; if (bus.ps_dm_wrb !== e_wrb) begin n_fail++; $display("FAIL rnd_wrb cyc %0d: got %b want %b", i, bus.ps_dm_wrb, e_wrb); end
         n_checks++; if (bus.dg_dm_add !== e_add) begin n_fail++; $display("FAIL rnd_add cyc %0d: got %h want %h", i, bus.dg_dm_add, e_add); end
         n_checks++; if (bus.core_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d: got %b want %b", i, bus.core_stall, e_stall); end
         n_checks++; if (bus.dma_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %b want %b", i, bus.dma_gnt, e_gnt); end
         n_checks++; if (bus.bc_dt !== e_bc) begin n_fail++; $display("FAIL rnd_bc cyc %0d: got %h want %h", i, bus.bc_dt, e_bc); end
         n_checks++; if (bus.dma_rvalid !== e_rvalid) begin n_fail++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", i, bus.dma_rvalid, e_rvalid); end
         n_checks++; if (bus.dma_rdt !== e_rdt) begin n_fail++; $display("FAIL rnd_rdt cyc %0d: got %h want %h", i, bus.dma_rdt, e_rdt); end
         n_checks++; if (dut.u_starve.r_cnt !== 4'(m_denied)) begin n_fail++; $display("FAIL rnd_starve cyc %0d: got %0d want %0d", i, dut.u_starve.r_cnt, m_denied); end
         at_end();
         if (!(bus.core_dm_cslt && e_stall)) begin
            drive_core(($urandom_range(0, 99) < 60), 1'($urandom), AW'($urandom), bus.core_dm_wdt);
         end
         if (!(bus.dma_req && !e_gnt)) begin
            drive_dma(($urandom_range(0, 99) < 45), 1'($urandom), AW'($urandom), DW'($urandom));
         end
      end
      // Let any pending DMA request be granted before dropping it.
      drive_core(1'b0, 1'b0, '0, '0);
      at_sample();
      at_end();
      drive_dma(1'b0, 1'b0, '0, '0);
      at_sample();
      at_end();
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 64; k++) begin
         tm_mem[k] = '0;
         shadow[k] = '0;
      end
      bus.dm_bc_dt = '0;
      drive_core(1'b0, 1'b0, '0, '0);
      drive_dma(1'b0, 1'b0, '0, '0);
      model_reset();
      #1 reset = 1'b0;
      test_reset();
      test_core_reads();
      test_dma_wr_rd();
      test_contention();
      test_mixed_writes();
      test_reset_mid_read();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench did not complete");
   end

endmodule : tb_dm_port_arbiter

`default_nettype wire

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Sequences and shares the single data-memory port of `memory` between two requesters: the core (DAG/program sequencer) and a DMA/host port.
- Drives the memory's `ps_dm_cslt`, `ps_dm_wrb`, `dg_dm_add` and `bc_dt`, and returns read data to the DMA side.
- Enforces the memory's timing: read data one cycle after the request cycle, write data held on `bc_dt` in the cycle after the write grant.
- Core has fixed priority; a starvation counter guarantees DMA forward progress.

Parameters:
- DMA_SIZE, 17, data-memory address width.
- DMD_SIZE, 16, data-memory data width.
- STARVE_LIM, 4, consecutive denied DMA-request cycles before DMA is force-granted (range 1..15).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- core_dm_cslt  in  1  core requests DM access this cycle.
- core_dm_wrb  in  1  core access is a write (1) or read (0).
- core_dm_add  in  DMA_SIZE  core DM address.
- core_dm_wdt  in  DMD_SIZE  core write data, valid in the cycle after the write request (execute+1).
- core_stall  out  1  core request not granted this cycle; core holds request.
- dma_req  in  1  DMA request; held until granted.
- dma_wrb  in  1  DMA write (1) or read (0).
- dma_add  in  DMA_SIZE  DMA address.
- dma_wdt  in  DMD_SIZE  DMA write data, valid with dma_req.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rvalid  out  1  dma_rdt valid.
- dma_rdt  out  DMD_SIZE  DMA read data.
- ps_dm_cslt  out  1  to memory.
- ps_dm_wrb  out  1  to memory.
- dg_dm_add  out  DMA_SIZE  to memory.
- bc_dt  out  DMD_SIZE  to memory; write data in grant+1 cycle.
- dm_bc_dt  in  DMD_SIZE  read data from memory.

Behaviour:
- Reset (reset=0, async): all outputs 0, including bc_dt; starve_cnt=0; wr_src=NONE; rd_pend=0.
- Arbitration is a combinational decision each cycle (owner = NONE/CORE/DMA), from the inputs and the registered force flag:
  - force = (starve_cnt == STARVE_LIM).
  - If force and dma_req: owner=DMA. Otherwise core_dm_cslt gives owner=CORE, else dma_req gives owner=DMA, else NONE.
- Memory drive:
  - ps_dm_cslt = (owner != NONE).
  - ps_dm_wrb and dg_dm_add come from the owner.
  - With owner=NONE: ps_dm_wrb=0 and dg_dm_add holds its last registered value, so the memory bypass compare stays stable.
- core_stall = core_dm_cslt & (owner != CORE).
- dma_gnt = (owner == DMA).
- Starvation counter (starve_cnt, 4-bit):
  - Increments when dma_req & ~dma_gnt, saturating at STARVE_LIM.
  - Clears on dma_gnt or when ~dma_req.
- Write pipeline:
  - On a write grant, wr_src <= owner. If DMA, wdata_q <= dma_wdt.
  - Next cycle: bc_dt = core_dm_wdt when wr_src=CORE, wdata_q when wr_src=DMA, previous value when NONE.
  - Back-to-back writes from any mix of sources pipeline with no bubble.
- Read return:
  - DMA read grant sets rd_pend for one cycle.
  - Next cycle: dma_rvalid=1 and dma_rdt=dm_bc_dt, latency 1.
  - dma_rdt holds its value while dma_rvalid=0.
  - Core read data is taken directly from dm_bc_dt by the core; this block does not touch it.
- Read-after-write to the same address in the next cycle relies on the memory bypass; the arbiter must present the correct bc_dt in that cycle.
- Simultaneous core+DMA with force=0: core wins, core_stall=0, dma_gnt=0.
- Simultaneous core+DMA with force=1: DMA wins, core_stall=1 for exactly that one cycle.
- DMA request withdrawn before grant is illegal; behaviour is unspecified. Checker flags it.
- Reset asserted mid-operation: pending write and read are discarded and no dma_rvalid follows. The memory's own latches are not reset, so the memory content at a write address granted in the reset cycle is unspecified.

Decomposition:
- Package dm_arb_pkg: owner encoding (NONE=2'd0, CORE=2'd1, DMA=2'd2) and the STARVE_W=4 constant.
- One sub-module, dm_starve_counter: saturating counter with clear and at-limit flag.
- Everything else stays inline.

Test Plan:
- Core-only reads: core reads 0x0000A then 0x0000F in consecutive cycles -> ps_dm_cslt=1 both cycles, core_stall=0, dg_dm_add follows the core address.
- DMA write then read: DMA writes 0x00003=0xFFEE, then reads 0x00003 -> dma_gnt 1 cycle each; bc_dt=0xFFEE in grant+1; dma_rvalid one cycle after the read grant with dma_rdt=0xFFEE.
- Contention with STARVE_LIM=4: core_dm_cslt and dma_req held high -> core granted 4 cycles, then DMA granted in cycle 5 with core_stall=1, then core resumes and starve_cnt=0.
- Mixed back-to-back writes: core write 0x00010 (core_dm_wdt=0x1234 next cycle) then DMA write 0x00011=0xABCD -> bc_dt shows 0x1234 then 0xABCD on consecutive cycles; a later read returns both values.
- Reset mid-read: assert reset in the cycle after a DMA read grant -> dma_rvalid stays 0, all outputs 0 asynchronously, normal grants resume after reset deasserts.
- Idle: no requests for 10 cycles -> ps_dm_cslt=0, dg_dm_add stable, starve_cnt=0.
